// File: rtl/demosaic_pkg.sv
// demosaic_pkg: shared limits and saturation-bound helpers for the
// demosaic multiplier pipeline.
package demosaic_pkg;

    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 6;

    // Working width for shift/round/clamp; must exceed product width + 1.
    localparam int BW = 128;

    function automatic logic signed [BW-1:0] sat_hi(input int w, input bit s);
        logic signed [BW-1:0] one;
        one = BW'(1);
        return s ? (one << (w - 1)) - one : (one << w) - one;
    endfunction

    function automatic logic signed [BW-1:0] sat_lo(input int w, input bit s);
        logic signed [BW-1:0] one;
        one = BW'(1);
        return s ? -(one << (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/demosaic_mul_sat.sv
// demosaic_mul_sat: combinational shift, optional rounding, and clamp.
// Rounding (half up) is enabled by the DEMOSAIC_MUL_ROUND_EN macro.
module demosaic_mul_sat
    import demosaic_pkg::*;
#(
    parameter int PW     = 28,
    parameter int DW     = 27,
    parameter int SIGNED = 0,
    parameter int SHIFT  = 0
) (
    input  logic [PW-1:0] prod,
    output logic [DW-1:0] dout,
    output logic          sat
);

    localparam logic signed [BW-1:0] HI = sat_hi(DW, SIGNED != 0);
    localparam logic signed [BW-1:0] LO = sat_lo(DW, SIGNED != 0);

`ifdef DEMOSAIC_MUL_ROUND_EN
    // Half of the dropped LSB weight; zero when SHIFT is zero.
    localparam logic signed [BW-1:0] HALF = (BW'(1) << SHIFT) >> 1;
`else
    localparam logic signed [BW-1:0] HALF = '0;
`endif

    logic signed [BW-1:0] ext;
    logic signed [BW-1:0] shd;

    always_comb begin
        if (SIGNED != 0) ext = BW'(signed'(prod));
        else             ext = BW'(prod);
        shd  = (ext + HALF) >>> SHIFT;
        dout = shd[DW-1:0];
        sat  = 1'b0;
        if (shd > HI) begin
            dout = HI[DW-1:0];
            sat  = 1'b1;
        end else if (shd < LO) begin
            dout = LO[DW-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/demosaic_root_mul_pipe.sv
// demosaic_root_mul_pipe: pipelined signed/unsigned multiplier with shift,
// saturation and valid/ready flow control. Option: DEMOSAIC_MUL_ROUND_EN.
module demosaic_root_mul_pipe
    import demosaic_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 20,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 27,
    parameter int SIGNED     = 0,
    parameter int SHIFT      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  sat
);

    localparam int P  = din0_WIDTH + din1_WIDTH;
    localparam int NS = (NUM_STAGE < NUM_STAGE_MIN) ? NUM_STAGE_MIN :
                        (NUM_STAGE > NUM_STAGE_MAX) ? NUM_STAGE_MAX :
                        NUM_STAGE;
    localparam int unused_id = ID;

    // Operands widened to P bits first, so the low P bits are exact.
    function automatic logic [P-1:0] mul(
        input logic [din0_WIDTH-1:0] a,
        input logic [din1_WIDTH-1:0] b
    );
        logic [P-1:0] ax;
        logic [P-1:0] bx;
        if (SIGNED != 0) begin
            ax = P'(signed'(a));
            bx = P'(signed'(b));
        end else begin
            ax = P'(a);
            bx = P'(b);
        end
        return ax * bx;
    endfunction

    logic                  advance;
    logic [NS-1:0]         vld;
    logic [P-1:0]          prod_d;
    logic [dout_WIDTH-1:0] ms_dout;
    logic                  ms_sat;

    assign advance   = ce && (!out_valid || out_ready);
    assign in_ready  = advance;
    assign out_valid = vld[NS-1];

    generate
        if (NS == 1) begin : g_ns1
            assign prod_d = mul(din0, din1);
        end else begin : g_nsn
            logic [din0_WIDTH-1:0] a_q;
            logic [din1_WIDTH-1:0] b_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= din0;
                    b_q <= din1;
                end
            end

            if (NS == 2) begin : g_ns2
                assign prod_d = mul(a_q, b_q);
            end else begin : g_ns3
                logic [P-1:0] p_q [2:NS-1];

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        for (int k = 2; k < NS; k++) p_q[k] <= '0;
                    end else if (advance) begin
                        p_q[2] <= mul(a_q, b_q);
                        for (int k = 3; k < NS; k++) p_q[k] <= p_q[k-1];
                    end
                end

                assign prod_d = p_q[NS-1];
            end
        end
    endgenerate

    demosaic_mul_sat #(
        .PW     (P),
        .DW     (dout_WIDTH),
        .SIGNED (SIGNED),
        .SHIFT  (SHIFT)
    ) u_sat (
        .prod (prod_d),
        .dout (ms_dout),
        .sat  (ms_sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld  <= '0;
            dout <= '0;
            sat  <= 1'b0;
        end else if (advance) begin
            vld  <= NS'({vld, in_valid});
            dout <= ms_dout;
            sat  <= ms_sat;
        end
    end

endmodule
